eq_gain_ramp_ctrl: RTL and testbench

- Owns the 10 per-band gain registers that feed the equalizer's gain_1..gain_10 inputs.
- Accepts gain-change requests over a valid/ready config interface and stores them as per-band targets.
- Once per audio sample (sample_tick), moves every live gain toward its target by at most RAMP_STEP, preventing zipper noise.
- Uses one shared step unit scanned across bands, then commits all 10 new gains atomically in a single cycle.

---
 rtl/eq_gain_ramp_ctrl.sv | 170 +++++++++++++++++
 tb/tb_eq_gain_ramp_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/eq_gain_ramp_ctrl.sv
// Per-band equalizer gain owner: stores requested targets and, once per sample tick,
// ramps every live gain toward its target through one shared step unit, then commits all bands together.
module eq_gain_ramp_ctrl #(
  parameter int GAIN_WIDTH = 8,
  parameter int RAMP_STEP  = 4,
  parameter int RESET_GAIN = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_tick,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [3:0]               cfg_band,
  input  logic [GAIN_WIDTH-1:0]    cfg_gain,
  input  logic                     err_clr,
  output logic [10*GAIN_WIDTH-1:0] gains_out,
  output logic                     busy,
  output logic                     ramping,
  output logic                     err_band,
  output logic                     tick_overrun
);

  localparam int NB = 10;
  localparam logic [GAIN_WIDTH-1:0] RST_G  = GAIN_WIDTH'(RESET_GAIN);
  localparam logic [GAIN_WIDTH:0]   STEP_W = (GAIN_WIDTH + 1)'(RAMP_STEP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic [3:0]            idx_r, idx_s;
  logic [GAIN_WIDTH-1:0] target_r [NB];
  logic [GAIN_WIDTH-1:0] shadow_r [NB];
  logic [GAIN_WIDTH-1:0] gain_r   [NB];
  logic [GAIN_WIDTH-1:0] step_next_s;
  logic                  cfg_fire_s, band_ok_s;
  logic                  mismatch_commit_s, mismatch_idle_s;
  logic                  ramping_r, err_band_r, tick_overrun_r;

  // Move cur toward tgt by at most RAMP_STEP; the extra bit keeps the differences from wrapping.
  function automatic logic [GAIN_WIDTH-1:0] ramp_step(input logic [GAIN_WIDTH-1:0] cur,
                                                      input logic [GAIN_WIDTH-1:0] tgt);
    logic [GAIN_WIDTH:0] c, t, d, n;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (c < t) begin
      d = t - c;
      n = c + ((d < STEP_W) ? d : STEP_W);
    end else if (c > t) begin
      d = c - t;
      n = c - ((d < STEP_W) ? d : STEP_W);
    end else begin
      d = {(GAIN_WIDTH + 1){1'b0}};
      n = c;
    end
    return n[GAIN_WIDTH-1:0];
  endfunction

  assign cfg_ready  = (state_r == IDLE);
  assign busy       = (state_r != IDLE);
  assign cfg_fire_s = cfg_valid && (state_r == IDLE);
  assign band_ok_s  = (cfg_band <= 4'd9);
  assign step_next_s = ramp_step(gain_r[idx_r], target_r[idx_r]);
  assign ramping      = ramping_r;
  assign err_band     = err_band_r;
  assign tick_overrun = tick_overrun_r;

  for (genvar b = 0; b < NB; b++) begin : g_out
    assign gains_out[b*GAIN_WIDTH +: GAIN_WIDTH] = gain_r[b];
  end

  // Mismatch detection: at commit (shadow vs target) and in idle (live vs post-write target).
  always_comb begin
    mismatch_commit_s = 1'b0;
    mismatch_idle_s   = 1'b0;
    for (int b = 0; b < NB; b++) begin
      mismatch_commit_s = mismatch_commit_s | (shadow_r[b] != target_r[b]);
      mismatch_idle_s   = mismatch_idle_s |
                          (gain_r[b] != ((cfg_fire_s && band_ok_s && (cfg_band == 4'(b)))
                                         ? cfg_gain : target_r[b]));
    end
  end

  // State register and band index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
    end
  end

  // Next-state logic for the tick -> scan -> commit sequence.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (sample_tick) begin
          state_s = SCAN;
          idx_s   = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (idx_r == 4'd9) begin
          state_s = COMMIT;
          idx_s   = 4'd0;
        end else begin
          idx_s = idx_r + 4'd1;
        end
      end
      COMMIT: begin
        state_s = IDLE;
        idx_s   = 4'd0;
      end
      default: begin
        state_s = IDLE;
        idx_s   = 4'd0;
      end
    endcase
  end

  // Targets, shadow scan results, atomic commit, and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) begin
        target_r[b] <= RST_G;
        shadow_r[b] <= RST_G;
        gain_r[b]   <= RST_G;
      end
      ramping_r      <= 1'b0;
      err_band_r     <= 1'b0;
      tick_overrun_r <= 1'b0;
    end else begin
      if (cfg_fire_s && band_ok_s) begin
        target_r[cfg_band] <= cfg_gain;
      end
      if (state_r == SCAN) begin
        shadow_r[idx_r] <= step_next_s;
      end
      if (state_r == COMMIT) begin
        for (int b = 0; b < NB; b++) begin
          gain_r[b] <= shadow_r[b];
        end
        ramping_r <= mismatch_commit_s;
      end else if (state_r == IDLE) begin
        ramping_r <= mismatch_idle_s;
      end
      // A new error on the same edge as err_clr keeps the flag set.
      if (cfg_fire_s && !band_ok_s) begin
        err_band_r <= 1'b1;
      end else if (err_clr) begin
        err_band_r <= 1'b0;
      end
      if (sample_tick && (state_r != IDLE)) begin
        tick_overrun_r <= 1'b1;
      end else if (err_clr) begin
        tick_overrun_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eq_gain_ramp_ctrl.sv
// Directed, table-driven bench for eq_gain_ramp_ctrl (GAIN_WIDTH=8, RAMP_STEP=4, RESET_GAIN=0).
module tb_eq_gain_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, sample_tick, cfg_valid, cfg_ready, err_clr;
  logic [3:0]  cfg_band;
  logic [7:0]  cfg_gain;
  logic [79:0] gains_out;
  logic        busy, ramping, err_band, tick_overrun;

  int checks = 0;
  int errors = 0;

  eq_gain_ramp_ctrl #(.GAIN_WIDTH(8), .RAMP_STEP(4), .RESET_GAIN(0)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_band(cfg_band), .cfg_gain(cfg_gain), .err_clr(err_clr),
    .gains_out(gains_out), .busy(busy), .ramping(ramping), .err_band(err_band),
    .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         wr;
    logic [3:0] band;
    logic [7:0] gain;
    int         ticks;
    int         ca;
    logic [7:0] va;
    int         cb;
    logic [7:0] vb;
    bit         rmp;
  } vec_t;

  vec_t vt [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] g(input int b);
    return gains_out[b*8 +: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] band, input logic [7:0] gain);
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_band  = band;
    cfg_gain  = gain;
    while (!cfg_ready && n < 50) begin
      step();
      n++;
    end
    check("write_ready", {31'd0, cfg_ready}, 32'd1);
    step();
    cfg_valid = 1'b0;
  endtask

  // Tick, then verify gains_out holds its old value and busy stays high until exactly edge k+11.
  task automatic do_tick();
    logic [79:0] pre;
    int bad;
    pre = gains_out;
    bad = 0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    if (!(busy === 1'b1 && gains_out === pre)) bad++;
    repeat (10) begin
      step();
      if (!(busy === 1'b1 && gains_out === pre)) bad++;
    end
    step();
    if (busy !== 1'b0) bad++;
    check("tick_latency", bad, 0);
    repeat (9) step();
  endtask

  initial begin
    logic [79:0] pre;
    int bad;
    rst_n = 1'b0; sample_tick = 1'b0; cfg_valid = 1'b0; err_clr = 1'b0;
    cfg_band = 4'd0; cfg_gain = 8'd0;

    vt[0]  = '{1'b1, 4'd2, 8'd10,  0,  2, 8'd0,   0, 8'd0,   1'b1};
    vt[1]  = '{1'b0, 4'd0, 8'd0,   1,  2, 8'd4,   0, 8'd0,   1'b1};
    vt[2]  = '{1'b0, 4'd0, 8'd0,   1,  2, 8'd8,   5, 8'd0,   1'b1};
    vt[3]  = '{1'b0, 4'd0, 8'd0,   1,  2, 8'd10,  9, 8'd0,   1'b0};
    vt[4]  = '{1'b1, 4'd0, 8'd255, 0,  0, 8'd0,   2, 8'd10,  1'b1};
    vt[5]  = '{1'b1, 4'd9, 8'd255, 0,  9, 8'd0,   0, 8'd0,   1'b1};
    vt[6]  = '{1'b0, 4'd0, 8'd0,   64, 0, 8'd255, 9, 8'd255, 1'b0};
    vt[7]  = '{1'b1, 4'd0, 8'd250, 0,  0, 8'd255, 9, 8'd255, 1'b1};
    vt[8]  = '{1'b1, 4'd9, 8'd250, 0,  9, 8'd255, 0, 8'd255, 1'b1};
    vt[9]  = '{1'b0, 4'd0, 8'd0,   1,  0, 8'd251, 9, 8'd251, 1'b1};
    vt[10] = '{1'b0, 4'd0, 8'd0,   1,  0, 8'd250, 9, 8'd250, 1'b0};
    vt[11] = '{1'b1, 4'd2, 8'd10,  0,  2, 8'd10,  0, 8'd250, 1'b0};

    // Reset values
    repeat (3) step();
    rst_n = 1'b1;
    check("rst_gains", {31'd0, gains_out == 80'd0}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ramping", {31'd0, ramping}, 32'd0);
    check("rst_ready", {31'd0, cfg_ready}, 32'd1);
    check("rst_errs", {30'd0, err_band, tick_overrun}, 32'd0);

    // Table: writes and ramps, upward and downward
    for (int i = 0; i < 12; i++) begin
      if (vt[i].wr) do_write(vt[i].band, vt[i].gain);
      for (int t = 0; t < vt[i].ticks; t++) do_tick();
      check($sformatf("vec%0d_a", i), {24'd0, g(vt[i].ca)}, {24'd0, vt[i].va});
      check($sformatf("vec%0d_b", i), {24'd0, g(vt[i].cb)}, {24'd0, vt[i].vb});
      check($sformatf("vec%0d_ramp", i), {31'd0, ramping}, {31'd0, vt[i].rmp});
    end

    // Write and tick on the same edge; a second request waits out the busy period
    cfg_valid = 1'b1; cfg_band = 4'd5; cfg_gain = 8'd3; sample_tick = 1'b1;
    step();
    sample_tick = 1'b0; cfg_band = 4'd4; cfg_gain = 8'd7;
    check("sim_busy", {31'd0, busy}, 32'd1);
    bad = 0;
    repeat (10) begin
      step();
      if (cfg_ready !== 1'b0) bad++;
    end
    check("sim_ready_low", bad, 0);
    step();
    check("sim_ready_back", {31'd0, cfg_ready}, 32'd1);
    check("sim_band5", {24'd0, g(5)}, 32'd3);
    check("sim_band4_pre", {24'd0, g(4)}, 32'd0);
    check("sim_ramp_clear", {31'd0, ramping}, 32'd0);
    step();
    cfg_valid = 1'b0;
    check("sim_ramp_set", {31'd0, ramping}, 32'd1);
    do_tick();
    check("sim_band4_a", {24'd0, g(4)}, 32'd4);
    do_tick();
    check("sim_band4_b", {24'd0, g(4)}, 32'd7);
    check("sim_ramp_done", {31'd0, ramping}, 32'd0);

    // Out-of-range band: handshake completes, nothing changes
    pre = gains_out;
    do_write(4'd12, 8'd99);
    check("err_band_set", {31'd0, err_band}, 32'd1);
    check("err_ramp", {31'd0, ramping}, 32'd0);
    do_tick();
    check("err_no_gain", {31'd0, gains_out == pre}, 32'd1);

    // Overrun tick 5 cycles into a scan: one commit only
    do_write(4'd4, 8'd20);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    repeat (4) step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("overrun_set", {31'd0, tick_overrun}, 32'd1);
    repeat (6) step();
    check("overrun_commit", {24'd0, g(4)}, 32'd11);
    check("overrun_idle", {31'd0, busy}, 32'd0);
    repeat (25) step();
    check("overrun_single", {24'd0, g(4)}, 32'd11);
    check("overrun_no_rescan", {31'd0, busy}, 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_flags", {30'd0, err_band, tick_overrun}, 32'd0);
    err_clr = 1'b1;
    do_write(4'd13, 8'd1);
    err_clr = 1'b0;
    check("clr_set_wins", {31'd0, err_band}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_again", {31'd0, err_band}, 32'd0);

    // Reset in the middle of a scan
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    check("mid_rst_gains", {31'd0, gains_out == 80'd0}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, cfg_ready}, 32'd1);
    check("mid_rst_ramp", {31'd0, ramping}, 32'd0);
    repeat (15) step();
    check("mid_rst_no_commit", {31'd0, gains_out == 80'd0}, 32'd1);
    check("mid_rst_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
